// File: rtl/fetch_queue_unit.sv
// ---------------------------------------------------------------------------
// fetch_queue_unit
//
// Instruction-fetch stage. Owns the word-aligned program counter, issues
// pipelined reads to a synchronous instruction memory (data returns one
// enabled cycle after the request), buffers returned words in a DEPTH-entry
// prefetch queue and presents the queue head to decode. Conditional branches
// are resolved here; a taken branch flushes the queue, drops any in-flight
// response and redirects the PC.
//
// Optional feature macro: FETCH_BRANCH_STATS_EN
//   When defined, adds saturating taken / not-taken branch counters.
//
// Ports
//   clk             core clock
//   reset           asynchronous, active-high reset
//   clk_en          global enable; when low all state holds and nothing issues
//   halt            stop request from decode (latched into the FSM)
//   imem_a          instruction memory byte address {pc, 2'b00}
//   imem_en         read request this cycle (combinational)
//   imem_v          read data, valid the enabled cycle after the request
//   instr_valid     queue head valid
//   instr_ready     decode accepts the head
//   instr_data      queue head word
//   instr_pc        byte address of the queue head
//   br_valid        branch resolved this cycle
//   br_cond         condition code (0..15)
//   br_flags        {N,Z,C,V}
//   br_target       branch byte target (bits [1:0] ignored)
//   halted          halt taken and queue drained
//   br_taken_cnt    (FETCH_BRANCH_STATS_EN) saturating taken count
//   br_nottaken_cnt (FETCH_BRANCH_STATS_EN) saturating not-taken count
//   dbg_state       current FSM state (0 RUN, 1 HALT_DRAIN, 2 HALTED)
//
// Handshakes: instr_valid/instr_ready is a strict valid/ready pair. The head
// is consumed at an enabled rising edge where both are high; instr_valid
// never depends on instr_ready, and the head stays stable until consumed or
// flushed by a taken branch.
// ---------------------------------------------------------------------------
module fetch_queue_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic              halt,
    output logic [ADDR_W-1:0] imem_a,
    output logic              imem_en,
    input  logic [31:0]       imem_v,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              br_valid,
    input  logic [3:0]        br_cond,
    input  logic [3:0]        br_flags,
    input  logic [ADDR_W-1:0] br_target,
    output logic              halted,
`ifdef FETCH_BRANCH_STATS_EN
    output logic [31:0]       br_taken_cnt,
    output logic [31:0]       br_nottaken_cnt,
`endif
    output logic [1:0]        dbg_state
);

    localparam int PW = ADDR_W - 2;           // word-index width of the PC
    localparam int AW = $clog2(DEPTH);        // queue pointer width
    localparam int CW = $clog2(DEPTH) + 1;    // occupancy width (0..DEPTH)
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_HALT_DRAIN = 2'd1,
        ST_HALTED     = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_halted;
    logic [PW-1:0]   r_pc;
    logic [PW-1:0]   r_req_pc;     // PC of the request whose data is in flight
    logic            r_inflight;
    logic [CW-1:0]   r_count;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [31:0]     r_q_data [DEPTH];
    logic [PW-1:0]   r_q_pc   [DEPTH];

    logic            w_cond_true;
    logic            w_taken;
    logic [CW:0]     w_occ;
    logic            w_room;
    logic            w_issue;
    logic            w_push;
    logic            w_pop;
    logic            w_flag_n;
    logic            w_flag_z;
    logic            w_flag_c;
    logic            w_flag_v;
    logic            w_unused_bits;

    assign w_flag_n = br_flags[3];
    assign w_flag_z = br_flags[2];
    assign w_flag_c = br_flags[1];
    assign w_flag_v = br_flags[0];

    // Byte-offset bits of the target are meaningless for word fetch.
    assign w_unused_bits = &{1'b0, br_target[1:0]};

    // Condition evaluation against {N,Z,C,V}.
    always_comb begin
        w_cond_true = 1'b0;
        case (br_cond)
            4'd0:  w_cond_true = w_flag_z;
            4'd1:  w_cond_true = ~w_flag_z;
            4'd2:  w_cond_true = w_flag_c;
            4'd3:  w_cond_true = ~w_flag_c;
            4'd4:  w_cond_true = w_flag_n;
            4'd5:  w_cond_true = ~w_flag_n;
            4'd6:  w_cond_true = w_flag_v;
            4'd7:  w_cond_true = ~w_flag_v;
            4'd8:  w_cond_true = w_flag_c & ~w_flag_z;
            4'd9:  w_cond_true = ~w_flag_c | w_flag_z;
            4'd10: w_cond_true = (w_flag_n == w_flag_v);
            4'd11: w_cond_true = (w_flag_n != w_flag_v);
            4'd12: w_cond_true = ~w_flag_z & (w_flag_n == w_flag_v);
            4'd13: w_cond_true = w_flag_z | (w_flag_n != w_flag_v);
            4'd14: w_cond_true = 1'b1;
            default: w_cond_true = 1'b0;
        endcase
    end

    // Branches only act while running and on enabled cycles.
    assign w_taken = clk_en & br_valid & w_cond_true & (r_state == ST_RUN);

    // A new request reserves a queue slot: occupancy plus the response that
    // lands this cycle must leave room, so the tail can never overflow.
    assign w_occ   = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    assign w_room  = (w_occ < DEPTH_C);
    assign w_issue = ~reset & clk_en & (r_state == ST_RUN) & w_room & ~w_taken;

    // A taken branch in the same cycle discards the arriving response.
    assign w_push  = clk_en & r_inflight & ~w_taken;
    assign w_pop   = clk_en & instr_valid & instr_ready;

    assign imem_en     = w_issue;
    assign imem_a      = {r_pc, 2'b00};
    assign instr_valid = (r_count != '0);
    assign instr_data  = r_q_data[r_rd_ptr];
    assign instr_pc    = {r_q_pc[r_rd_ptr], 2'b00};
    assign halted      = r_halted;
    assign dbg_state   = r_state;

    // PC, in-flight tracking and prefetch queue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc       <= RESET_PC[ADDR_W-1:2];
            r_req_pc   <= '0;
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q_data[i] <= '0;
                r_q_pc[i]   <= '0;
            end
        end else if (clk_en) begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_pc     <= r_pc + PW'(1);
                r_req_pc <= r_pc;
            end
            if (w_taken) begin
                // Flush wins over any same-cycle push or pop.
                r_pc     <= br_target[ADDR_W-1:2];
                r_count  <= '0;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_q_data[r_wr_ptr] <= imem_v;
                    r_q_pc[r_wr_ptr]   <= r_req_pc;
                    r_wr_ptr           <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Run / halt control. HALTED is terminal until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
        end else if (clk_en) begin
            case (r_state)
                ST_RUN: begin
                    if (halt) begin
                        r_state <= ST_HALT_DRAIN;
                    end
                end
                ST_HALT_DRAIN: begin
                    if ((r_count == '0) && !r_inflight) begin
                        r_state  <= ST_HALTED;
                        r_halted <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    r_state  <= ST_HALTED;
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state  <= ST_RUN;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_BRANCH_STATS_EN
    logic [31:0] r_taken_cnt;
    logic [31:0] r_nottaken_cnt;

    // Saturating outcome counters for branches resolved while running.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_taken_cnt    <= '0;
            r_nottaken_cnt <= '0;
        end else if (clk_en && br_valid && (r_state == ST_RUN)) begin
            if (w_cond_true) begin
                if (r_taken_cnt != 32'hFFFF_FFFF) begin
                    r_taken_cnt <= r_taken_cnt + 32'd1;
                end
            end else begin
                if (r_nottaken_cnt != 32'hFFFF_FFFF) begin
                    r_nottaken_cnt <= r_nottaken_cnt + 32'd1;
                end
            end
        end
    end

    assign br_taken_cnt    = r_taken_cnt;
    assign br_nottaken_cnt = r_nottaken_cnt;
`endif

endmodule
